// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - Pong frame-rate game state: paddles, ball, collisions, score.
// Two-stage update per frame_tick: candidates at T+1, resolve and commit at T+2.
module pong_game_engine #(
   parameter int PADDLE_SPEED = 4,
   parameter int BALL_SPEED   = 2,
   parameter int WIN_SCORE    = 9,
   parameter int PAUSE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   input  logic       serve,
   output logic [9:0] paddle_left_pos,
   output logic [9:0] paddle_right_pos,
   output logic [9:0] ball_pos_x,
   output logic [9:0] ball_pos_y,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic [1:0] game_state,
   output logic       update_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_POINT = 2'd2;
   localparam logic [1:0] ST_OVER  = 2'd3;

   localparam logic [10:0] LP_PS   = 11'(PADDLE_SPEED);
   localparam logic [10:0] LP_BS   = 11'(BALL_SPEED);
   localparam logic [3:0]  LP_WIN  = 4'(WIN_SCORE);
   localparam logic [9:0]  LP_X0   = 10'd315;
   localparam logic [9:0]  LP_Y0   = 10'd235;
   localparam logic [9:0]  LP_PAD0 = 10'd215;
   localparam int          PCW     = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
   localparam logic [PCW-1:0] LP_PAUSE_LAST = PCW'(PAUSE_FRAMES - 1);
   localparam logic [PCW-1:0] LP_PAUSE_ONE  = PCW'(1);

   logic [1:0]     r_state;
   logic [9:0]     r_pl, r_pr, r_x, r_y;
   logic           r_dx, r_dy;
   logic [3:0]     r_sl, r_sr;
   logic [PCW-1:0] r_pause;
   logic           r_s1, r_s2, r_done;
   logic [9:0]     r_pl_nxt, r_pr_nxt;
   logic [10:0]    r_nx, r_ny;

   logic [10:0] w_x11, w_y11, w_nx, w_ny;
   logic [9:0]  w_x_res, w_y_res;
   logic        w_dx_res, w_dy_res, w_pt_l, w_pt_r, w_ov_l, w_ov_r, w_over_serve;
   logic [3:0]  w_sl_inc, w_sr_inc;

   function automatic logic [9:0] f_paddle(input logic [9:0] pos, input logic up, input logic dn);
      logic [10:0] sum;
      logic [10:0] dif;
      sum = {1'b0, pos} + LP_PS;
      dif = {1'b0, pos} - LP_PS;
      if (up && !dn)
         f_paddle = ({1'b0, pos} < LP_PS) ? 10'd0 : dif[9:0];
      else if (dn && !up)
         f_paddle = (sum > 11'd430) ? 10'd430 : sum[9:0];
      else
         f_paddle = pos;
   endfunction

   assign w_x11        = {1'b0, r_x};
   assign w_y11        = {1'b0, r_y};
   assign w_nx         = r_dx ? (w_x11 + LP_BS) : (w_x11 - LP_BS);
   assign w_ny         = r_dy ? (w_y11 + LP_BS) : (w_y11 - LP_BS);
   assign w_sl_inc     = r_sl + 4'd1;
   assign w_sr_inc     = r_sr + 4'd1;
   assign w_over_serve = serve && (r_state == ST_OVER);

   // Overlap is judged against this frame's post-move paddles.
   assign w_ov_l = (w_y11 + 11'd10 > {1'b0, r_pl_nxt}) && (w_y11 < {1'b0, r_pl_nxt} + 11'd50);
   assign w_ov_r = (w_y11 + 11'd10 > {1'b0, r_pr_nxt}) && (w_y11 < {1'b0, r_pr_nxt} + 11'd50);
   assign w_pt_r = !r_dx && (w_x11 < LP_BS);
   assign w_pt_l = r_dx && (r_nx > 11'd630);

   always_comb begin
      w_x_res  = r_nx[9:0];
      w_y_res  = r_ny[9:0];
      w_dx_res = r_dx;
      w_dy_res = r_dy;
      if (!r_dy && (w_y11 < LP_BS)) begin
         w_y_res  = 10'd0;
         w_dy_res = 1'b1;
      end else if (r_dy && (r_ny > 11'd470)) begin
         w_y_res  = 10'd470;
         w_dy_res = 1'b0;
      end
      if (!r_dx && (r_nx <= 11'd15) && (w_x11 >= 11'd16) && w_ov_l) begin
         w_x_res  = 10'd16;
         w_dx_res = 1'b1;
      end else if (r_dx && (r_nx >= 11'd611) && (w_x11 <= 11'd610) && w_ov_r) begin
         w_x_res  = 10'd610;
         w_dx_res = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pl     <= LP_PAD0;
         r_pr     <= LP_PAD0;
         r_x      <= LP_X0;
         r_y      <= LP_Y0;
         r_dx     <= 1'b1;
         r_dy     <= 1'b1;
         r_sl     <= 4'd0;
         r_sr     <= 4'd0;
         r_pause  <= '0;
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_done   <= 1'b0;
         r_pl_nxt <= LP_PAD0;
         r_pr_nxt <= LP_PAD0;
         r_nx     <= 11'd0;
         r_ny     <= 11'd0;
      end else begin
         r_s1   <= frame_tick && !r_s1 && !r_s2;
         // A restart out of OVER drops any candidates computed from frozen positions.
         r_s2   <= r_s1 && !w_over_serve;
         r_done <= r_s2;

         if (r_s1) begin
            r_pl_nxt <= f_paddle(r_pl, btn_l_up, btn_l_dn);
            r_pr_nxt <= f_paddle(r_pr, btn_r_up, btn_r_dn);
            r_nx     <= w_nx;
            r_ny     <= w_ny;
         end

         if (r_s2) begin
            if (r_state != ST_OVER) begin
               r_pl <= r_pl_nxt;
               r_pr <= r_pr_nxt;
            end
            if (r_state == ST_PLAY) begin
               if (w_pt_r) begin
                  r_sr    <= w_sr_inc;
                  r_x     <= LP_X0;
                  r_y     <= LP_Y0;
                  r_dx    <= 1'b0;
                  r_dy    <= 1'b1;
                  r_state <= (w_sr_inc == LP_WIN) ? ST_OVER : ST_POINT;
               end else if (w_pt_l) begin
                  r_sl    <= w_sl_inc;
                  r_x     <= LP_X0;
                  r_y     <= LP_Y0;
                  r_dx    <= 1'b1;
                  r_dy    <= 1'b1;
                  r_state <= (w_sl_inc == LP_WIN) ? ST_OVER : ST_POINT;
               end else begin
                  r_x  <= w_x_res;
                  r_y  <= w_y_res;
                  r_dx <= w_dx_res;
                  r_dy <= w_dy_res;
               end
            end else if (r_state == ST_POINT) begin
               if (r_pause == LP_PAUSE_LAST) begin
                  r_pause <= '0;
                  r_state <= ST_PLAY;
               end else begin
                  r_pause <= r_pause + LP_PAUSE_ONE;
               end
            end
         end

         if (serve && (r_state == ST_IDLE))
            r_state <= ST_PLAY;
         if (w_over_serve) begin
            r_sl    <= 4'd0;
            r_sr    <= 4'd0;
            r_x     <= LP_X0;
            r_y     <= LP_Y0;
            r_pl    <= LP_PAD0;
            r_pr    <= LP_PAD0;
            r_state <= ST_IDLE;
         end
      end
   end

   assign paddle_left_pos  = r_pl;
   assign paddle_right_pos = r_pr;
   assign ball_pos_x       = r_x;
   assign ball_pos_y       = r_y;
   assign score_left       = r_sl;
   assign score_right      = r_sr;
   assign game_state       = r_state;
   assign update_done      = r_done;

endmodule
